// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (fetch/load/store) and memory-side signals for mem_port_arbiter.
// slave  : arbiter view (requests and memory read data in, acks and memory requests out).
// master : environment view (drives requests and memory read data, observes everything else).
interface mem_port_arbiter_if;
  // Fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  // Load requester
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic [31:0] ld_data;
  // Store requester
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_type;
  logic        st_ack;
  // Memory side
  logic        mem_inst_req;
  logic [31:0] mem_inst_addr;
  logic [31:0] mem_inst_data;
  logic        mem_load_req;
  logic [31:0] mem_load_addr;
  logic [31:0] mem_load_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_wr_type;
  // Status
  logic        busy;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_type,
    input  mem_inst_data, mem_load_data,
    output if_ack, if_data, ld_ack, ld_data, st_ack,
    output mem_inst_req, mem_inst_addr, mem_load_req, mem_load_addr,
    output mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_type, busy
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_type,
    output mem_inst_data, mem_load_data,
    input  if_ack, if_data, ld_ack, ld_data, st_ack,
    input  mem_inst_req, mem_inst_addr, mem_load_req, mem_load_addr,
    input  mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_type, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, load and store requesters onto a single-access memory port.
// Priority is store > load > fetch, with fetch forced to win after STARVE_LIMIT consecutive
// losses. Each access runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP; all outputs
// are registered.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus_io  : requester and memory signals (mem_port_arbiter_if, slave modport)
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {SelNone, SelFetch, SelLoad, SelStore} sel_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [3:0] WaitInit  = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  sel_e        sel_q, sel_d, grant;
  logic [3:0]  starve_q, starve_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        if_ack_q, if_ack_d, ld_ack_q, ld_ack_d, st_ack_q, st_ack_d;
  logic [31:0] if_data_q, if_data_d, ld_data_q, ld_data_d;
  logic        inst_req_q, inst_req_d, load_req_q, load_req_d, wr_req_q, wr_req_d;
  logic [31:0] inst_addr_q, inst_addr_d, load_addr_q, load_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [2:0]  wr_type_q, wr_type_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    starve_d    = starve_q;
    wait_cnt_d  = wait_cnt_q;
    if_ack_d    = 1'b0;
    ld_ack_d    = 1'b0;
    st_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    ld_data_d   = ld_data_q;
    inst_req_d  = 1'b0;
    load_req_d  = 1'b0;
    wr_req_d    = 1'b0;
    inst_addr_d = inst_addr_q;
    load_addr_d = load_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_type_d   = wr_type_q;
    grant       = SelNone;

    unique case (state_q)
      StIdle: begin
        if (bus_io.if_req && (starve_q == StarveMax)) grant = SelFetch;
        else if (bus_io.st_req)                       grant = SelStore;
        else if (bus_io.ld_req)                       grant = SelLoad;
        else if (bus_io.if_req)                       grant = SelFetch;

        // Memory request and operands are launched on the grant edge, so they are valid
        // during ISSUE and the operand registers hold until the next grant of that port.
        case (grant)
          SelFetch: begin
            inst_req_d  = 1'b1;
            inst_addr_d = bus_io.if_addr;
          end
          SelLoad: begin
            load_req_d  = 1'b1;
            load_addr_d = bus_io.ld_addr;
          end
          SelStore: begin
            wr_req_d  = 1'b1;
            wr_addr_d = bus_io.st_addr;
            wr_data_d = bus_io.st_data;
            wr_type_d = bus_io.st_type;
          end
          default: ;
        endcase

        if (grant != SelNone) begin
          state_d = StIssue;
          sel_d   = grant;
        end

        if (!bus_io.if_req || (grant == SelFetch)) begin
          starve_d = '0;
        end else if (starve_q != StarveMax) begin
          starve_d = starve_q + 4'd1;
        end
      end
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = WaitInit;
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = StResp;
          case (sel_q)
            SelFetch: begin
              if_data_d = bus_io.mem_inst_data;
              if_ack_d  = 1'b1;
            end
            SelLoad: begin
              ld_data_d = bus_io.mem_load_data;
              ld_ack_d  = 1'b1;
            end
            SelStore: st_ack_d = 1'b1;
            default: ;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sel_q       <= SelNone;
      starve_q    <= '0;
      wait_cnt_q  <= '0;
      if_ack_q    <= 1'b0;
      ld_ack_q    <= 1'b0;
      st_ack_q    <= 1'b0;
      if_data_q   <= '0;
      ld_data_q   <= '0;
      inst_req_q  <= 1'b0;
      load_req_q  <= 1'b0;
      wr_req_q    <= 1'b0;
      inst_addr_q <= '0;
      load_addr_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_type_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      starve_q    <= starve_d;
      wait_cnt_q  <= wait_cnt_d;
      if_ack_q    <= if_ack_d;
      ld_ack_q    <= ld_ack_d;
      st_ack_q    <= st_ack_d;
      if_data_q   <= if_data_d;
      ld_data_q   <= ld_data_d;
      inst_req_q  <= inst_req_d;
      load_req_q  <= load_req_d;
      wr_req_q    <= wr_req_d;
      inst_addr_q <= inst_addr_d;
      load_addr_q <= load_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_type_q   <= wr_type_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_io.if_ack        = if_ack_q;
  assign bus_io.if_data       = if_data_q;
  assign bus_io.ld_ack        = ld_ack_q;
  assign bus_io.ld_data       = ld_data_q;
  assign bus_io.st_ack        = st_ack_q;
  assign bus_io.mem_inst_req  = inst_req_q;
  assign bus_io.mem_inst_addr = inst_addr_q;
  assign bus_io.mem_load_req  = load_req_q;
  assign bus_io.mem_load_addr = load_addr_q;
  assign bus_io.mem_wr_req    = wr_req_q;
  assign bus_io.mem_wr_addr   = wr_addr_q;
  assign bus_io.mem_wr_data   = wr_data_q;
  assign bus_io.mem_wr_type   = wr_type_q;
  assign bus_io.busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=1, STARVE_LIMIT=2).
// Request vectors are ordered {inst, load, wr}; ack vectors {if_ack, ld_ack, st_ack}.
module tb_mem_port_arbiter;

  localparam int unsigned Lat = 1;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LATENCY  (Lat),
    .STARVE_LIMIT (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reqs();
    return {29'd0, bus.mem_inst_req, bus.mem_load_req, bus.mem_wr_req};
  endfunction

  function automatic logic [31:0] acks();
    return {29'd0, bus.if_ack, bus.ld_ack, bus.st_ack};
  endfunction

  // Grant edge, ISSUE check, WAIT cycles, then RESP check.
  task automatic access(input string tag, input logic [2:0] exp_req, input logic [31:0] exp_addr,
                        input logic [2:0] exp_ack);
    logic [31:0] addr;
    tick();
    check({tag, "_req"}, reqs(), {29'd0, exp_req});
    addr = exp_req[2] ? bus.mem_inst_addr : (exp_req[1] ? bus.mem_load_addr : bus.mem_wr_addr);
    check({tag, "_addr"}, addr, exp_addr);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < Lat; i++) begin
      tick();
      check({tag, "_wait_req"}, reqs(), 32'd0);
      check({tag, "_wait_ack"}, acks(), 32'd0);
    end
    tick();
    check({tag, "_ack"}, acks(), {29'd0, exp_ack});
    check({tag, "_resp_req"}, reqs(), 32'd0);
  endtask

  task automatic idle(input string tag);
    tick();
    check({tag, "_ack"}, acks(), 32'd0);
    check({tag, "_req"}, reqs(), 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.if_req        = 1'b0;
    bus.if_addr       = '0;
    bus.ld_req        = 1'b0;
    bus.ld_addr       = '0;
    bus.st_req        = 1'b0;
    bus.st_addr       = '0;
    bus.st_data       = '0;
    bus.st_type       = '0;
    bus.mem_inst_data = '0;
    bus.mem_load_data = '0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_req", reqs(), 32'd0);
    check("rst_ack", acks(), 32'd0);
    check("rst_ld_data", bus.ld_data, 32'd0);
    check("rst_wr_addr", bus.mem_wr_addr, 32'd0);
    tick();
    tick();
    #2 reset_n = 1'b1;
    idle("post_rst");

    // Single load, latency 1
    bus.ld_req        = 1'b1;
    bus.ld_addr       = 32'h0000_0100;
    bus.mem_load_data = 32'hDEAD_BEEF;
    access("ld1", 3'b010, 32'h0000_0100, 3'b010);
    check("ld1_data", bus.ld_data, 32'hDEAD_BEEF);
    bus.ld_req = 1'b0;
    idle("ld1_idle");
    check("ld1_data_hold", bus.ld_data, 32'hDEAD_BEEF);

    // Single word store
    bus.st_req  = 1'b1;
    bus.st_addr = 32'h0000_0040;
    bus.st_data = 32'h1122_3344;
    bus.st_type = 3'b010;
    tick();
    check("st1_req", reqs(), 32'd1);
    check("st1_addr", bus.mem_wr_addr, 32'h0000_0040);
    check("st1_data", bus.mem_wr_data, 32'h1122_3344);
    check("st1_type", {29'd0, bus.mem_wr_type}, 32'd2);
    tick();
    check("st1_wait_req", reqs(), 32'd0);
    tick();
    check("st1_ack", acks(), 32'd1);
    bus.st_req = 1'b0;
    idle("st1_idle");
    check("st1_addr_hold", bus.mem_wr_addr, 32'h0000_0040);

    // All three at once: store, load, fetch
    bus.st_req        = 1'b1;
    bus.st_addr       = 32'h0000_0080;
    bus.st_data       = 32'hAABB_CCDD;
    bus.st_type       = 3'b000;
    bus.ld_req        = 1'b1;
    bus.ld_addr       = 32'h0000_0200;
    bus.if_req        = 1'b1;
    bus.if_addr       = 32'h0000_0300;
    bus.mem_load_data = 32'h1234_5678;
    bus.mem_inst_data = 32'hCAFE_F00D;
    access("mix_st", 3'b001, 32'h0000_0080, 3'b001);
    check("mix_st_data", bus.mem_wr_data, 32'hAABB_CCDD);
    check("mix_st_type", {29'd0, bus.mem_wr_type}, 32'd0);
    bus.st_req = 1'b0;
    idle("mix_gap1");
    access("mix_ld", 3'b010, 32'h0000_0200, 3'b010);
    check("mix_ld_data", bus.ld_data, 32'h1234_5678);
    bus.ld_req = 1'b0;
    idle("mix_gap2");
    access("mix_if", 3'b100, 32'h0000_0300, 3'b100);
    check("mix_if_data", bus.if_data, 32'hCAFE_F00D);
    bus.if_req = 1'b0;
    idle("mix_gap3");

    // Starvation: loads keep winning until the limit forces a fetch
    bus.if_req        = 1'b1;
    bus.if_addr       = 32'h0000_0500;
    bus.ld_req        = 1'b1;
    bus.ld_addr       = 32'h0000_0600;
    bus.mem_load_data = 32'h600D_D00D;
    bus.mem_inst_data = 32'h1357_9BDF;
    access("stv_ld1", 3'b010, 32'h0000_0600, 3'b010);
    idle("stv_gap1");
    access("stv_ld2", 3'b010, 32'h0000_0600, 3'b010);
    idle("stv_gap2");
    access("stv_if", 3'b100, 32'h0000_0500, 3'b100);
    check("stv_if_data", bus.if_data, 32'h1357_9BDF);
    bus.if_req = 1'b0;
    idle("stv_gap3");
    access("stv_ld3", 3'b010, 32'h0000_0600, 3'b010);
    bus.ld_req = 1'b0;
    idle("stv_gap4");

    // Load dropped during WAIT still completes
    bus.ld_req        = 1'b1;
    bus.ld_addr       = 32'h0000_0700;
    bus.mem_load_data = 32'h0BAD_F00D;
    tick();
    check("drop_req", reqs(), 32'd2);
    tick();
    bus.ld_req = 1'b0;
    tick();
    check("drop_ack", acks(), 32'd2);
    check("drop_data", bus.ld_data, 32'h0BAD_F00D);
    idle("drop_idle1");
    idle("drop_idle2");

    // Reset during WAIT abandons the access; pending load is serviced afterwards
    bus.ld_req        = 1'b1;
    bus.ld_addr       = 32'h0000_0800;
    bus.mem_load_data = 32'h8765_4321;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_req", reqs(), 32'd0);
    check("arst_ld_data", bus.ld_data, 32'd0);
    check("arst_if_data", bus.if_data, 32'd0);
    check("arst_ld_addr", bus.mem_load_addr, 32'd0);
    check("arst_wr_data", bus.mem_wr_data, 32'd0);
    tick();
    check("arst_hold_ack", acks(), 32'd0);
    check("arst_hold_busy", {31'd0, bus.busy}, 32'd0);
    #2 reset_n = 1'b1;
    access("arst_ld", 3'b010, 32'h0000_0800, 3'b010);
    check("arst_ld_data2", bus.ld_data, 32'h8765_4321);
    bus.ld_req = 1'b0;
    idle("arst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
